// File: rtl/secded_pkg.sv
// Shared status encoding, lock constant and elaboration-time codeword helpers
// for the key-locked SEC-DED decoder.
package secded_pkg;

  typedef enum logic [1:0] {
    STAT_CLEAN  = 2'b00,
    STAT_CORR   = 2'b01,
    STAT_UNCORR = 2'b10
  } stat_e;

  localparam logic [3:0] LOCK_NIBBLE = 4'b0110;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Hamming check bits r (smallest r with 2^r >= data_w + r + 1) plus overall parity.
  function automatic int calc_par_w(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < (data_w + r + 1)) r++;
    return r + 1;
  endfunction

  // Data index carried at codeword position pos; -1 for check-bit positions.
  function automatic int pos_to_didx(input int pos);
    int n;
    if ((pos < 3) || is_pow2(pos)) return -1;
    n = 0;
    for (int p = 3; p < pos; p++) begin
      if (!is_pow2(p)) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/secded_lock_dec_key_lut4.sv
// 4:1 lookup that recombines the two halves of a split parity tree through a key nibble.
module key_lut4 (
  input  logic       i_a,
  input  logic       i_b,
  input  logic [3:0] i_key,
  output logic       o_y
);

  logic [1:0] w_sel;

  assign w_sel = {i_a, i_b};
  assign o_y   = i_key[w_sel];

endmodule

// File: rtl/secded_lock_dec.sv
// Two-stage SEC-DED decoder: stage 1 registers data with the key-locked syndrome and
// overall parity, stage 2 registers corrected data and status; saturating error counters.
module secded_lock_dec
  import secded_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NLOCK  = 4,
  parameter  int CNT_W  = 16,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int KEY_W  = 4 * NLOCK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PAR_W-1:0]  in_chk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_stat,
  input  logic              key_shift,
  input  logic              key_bit,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam int SYN_W = PAR_W - 1;
  localparam int NPOS  = DATA_W + PAR_W - 1;

  typedef logic [NPOS:1] pos_vec_t;

  // Positions whose index has bit bitn set: the full parity tree of s[bitn].
  function automatic pos_vec_t syn_mask(input int bitn);
    pos_vec_t m;
    m = '0;
    for (int p = 1; p <= NPOS; p++) begin
      m[p] = (((p >> bitn) & 1) == 1);
    end
    return m;
  endfunction

  // Lower-index half (rounded down) of the terms of s[bitn]; the rest form the upper half.
  function automatic pos_vec_t lo_half_mask(input int bitn);
    pos_vec_t m;
    int       nt;
    int       k;
    m  = '0;
    nt = 0;
    for (int p = 1; p <= NPOS; p++) begin
      if (((p >> bitn) & 1) == 1) nt++;
    end
    k = 0;
    for (int p = 1; p <= NPOS; p++) begin
      if (((p >> bitn) & 1) == 1) begin
        if (k < (nt / 2)) m[p] = 1'b1;
        k++;
      end
    end
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + 1'b1);
  endfunction

  logic                 w_en;
  logic                 w_xfer;
  pos_vec_t             w_cw_p0;
  logic [SYN_W-1:0]     w_syn_p0;
  logic                 w_par_p0;
  logic [DATA_W-1:0]    w_flip_p1;
  logic                 w_in_range_p1;
  logic [DATA_W-1:0]    w_data_p1;
  stat_e                w_stat_p1;

  logic                 r_vld_p1;
  logic [DATA_W-1:0]    r_data_p1;
  logic [SYN_W-1:0]     r_syn_p1;
  logic                 r_par_p1;
  logic                 r_vld_p2;
  logic [DATA_W-1:0]    r_data_p2;
  stat_e                r_stat_p2;
  logic [KEY_W-1:0]     r_key;
  logic [CNT_W-1:0]     r_corr_cnt;
  logic [CNT_W-1:0]     r_uncorr_cnt;

  assign w_en     = !r_vld_p2 || out_ready;
  assign w_xfer   = r_vld_p2 && out_ready;
  assign in_ready = w_en;

  // Stage 0: assemble the Hamming codeword and compute the locked syndrome
  for (genvar p = 1; p <= NPOS; p++) begin : g_cw
    if (is_pow2(p)) begin : g_chk
      assign w_cw_p0[p] = in_chk[$clog2(p)];
    end else begin : g_dat
      assign w_cw_p0[p] = in_data[pos_to_didx(p)];
    end
  end

  for (genvar i = 0; i < SYN_W; i++) begin : g_syn
    localparam pos_vec_t MASK = syn_mask(i);
    if (i < NLOCK) begin : g_lock
      localparam pos_vec_t LO = lo_half_mask(i);
      logic w_a;
      logic w_b;
      assign w_a = ^(w_cw_p0 & LO);
      assign w_b = ^(w_cw_p0 & MASK & ~LO);
      key_lut4 u_lut (
        .i_a   (w_a),
        .i_b   (w_b),
        .i_key (r_key[4*i +: 4]),
        .o_y   (w_syn_p0[i])
      );
    end else begin : g_open
      assign w_syn_p0[i] = ^(w_cw_p0 & MASK);
    end
  end

  assign w_par_p0 = ^{in_data, in_chk};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key <= '0;
    end else if (key_shift) begin
      r_key <= {r_key[KEY_W-2:0], key_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else if (w_en) begin
      r_vld_p1 <= in_valid;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // Stage 1: data, syndrome and overall parity of the accepted beat
  always_ff @(posedge clk) begin
    if (w_en && in_valid) begin
      r_data_p1 <= in_data;
      r_syn_p1  <= w_syn_p0;
      r_par_p1  <= w_par_p0;
    end
  end

  for (genvar p = 3; p <= NPOS; p++) begin : g_flip
    if (!is_pow2(p)) begin : g_d
      assign w_flip_p1[pos_to_didx(p)] = (r_syn_p1 == SYN_W'(p));
    end
  end

  assign w_in_range_p1 = (r_syn_p1 <= SYN_W'(NPOS));

  // Syndrome zero with odd parity points at the overall bit, which needs no data flip.
  always_comb begin
    w_data_p1 = r_data_p1;
    w_stat_p1 = STAT_CLEAN;
    if (r_par_p1) begin
      if (w_in_range_p1) begin
        w_stat_p1 = STAT_CORR;
        w_data_p1 = r_data_p1 ^ w_flip_p1;
      end else begin
        w_stat_p1 = STAT_UNCORR;
      end
    end else if (r_syn_p1 != '0) begin
      w_stat_p1 = STAT_UNCORR;
    end
  end

  // Stage 2: corrected data and status, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_p2 <= '0;
      r_stat_p2 <= STAT_CLEAN;
    end else if (w_en && r_vld_p1) begin
      r_data_p2 <= w_data_p1;
      r_stat_p2 <= w_stat_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_xfer) begin
      if (r_stat_p2 == STAT_CORR)   r_corr_cnt   <= sat_inc(r_corr_cnt);
      if (r_stat_p2 == STAT_UNCORR) r_uncorr_cnt <= sat_inc(r_uncorr_cnt);
    end
  end

  assign out_valid  = r_vld_p2;
  assign out_data   = r_data_p2;
  assign out_stat   = r_stat_p2;
  assign corr_cnt   = r_corr_cnt;
  assign uncorr_cnt = r_uncorr_cnt;

endmodule

// File: tb/tb_secded_lock_dec.sv
// Bench for secded_lock_dec: directed scenarios plus randomized traffic against a
// position-arithmetic SEC-DED reference and a two-slot stall-aware timing model.
module tb_secded_lock_dec;

  localparam int DW   = 32;
  localparam int PW   = 7;
  localparam int NL   = 4;
  localparam int KW   = 16;
  localparam int CW   = 4;
  localparam int NPOS = DW + PW - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [PW-1:0] in_chk = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [1:0]    out_stat;
  logic          key_shift = 1'b0;
  logic          key_bit = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit            m_v1 = 0;
  bit            m_v2 = 0;
  logic [DW-1:0] m_d1 = '0;
  logic [PW-1:0] m_c1 = '0;
  logic [KW-1:0] m_k1 = '0;
  logic [DW-1:0] m_d2 = '0;
  logic [1:0]    m_s2 = '0;
  logic [KW-1:0] m_key = '0;
  int            m_corr = 0;
  int            m_unc = 0;

  always #5 clk = ~clk;

  secded_lock_dec #(.DATA_W(DW), .NLOCK(NL), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_chk     (in_chk),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_stat   (out_stat),
    .key_shift  (key_shift),
    .key_bit    (key_bit),
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  function automatic bit is_p2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Codeword position of data bit di: the di-th non-power-of-two position.
  function automatic int dpos(input int di);
    int n;
    n = -1;
    for (int p = 1; p <= NPOS; p++) begin
      if (!is_p2(p)) begin
        n++;
        if (n == di) return p;
      end
    end
    return 0;
  endfunction

  // Check bit i equals bit i of the XOR of the positions of all set data bits.
  function automatic logic [PW-1:0] encode(input logic [DW-1:0] d);
    int            s;
    logic [PW-1:0] c;
    s = 0;
    for (int i = 0; i < DW; i++) if (d[i]) s ^= dpos(i);
    c[PW-2:0] = s[PW-2:0];
    c[PW-1]   = (^d) ^ (^c[PW-2:0]);
    return c;
  endfunction

  // Syndrome = XOR of the position numbers of all set codeword bits, then key override.
  function automatic logic [DW+1:0] ref_decode(input logic [DW-1:0] d, input logic [PW-1:0] c,
                                               input logic [KW-1:0] k);
    int            s;
    bit            p;
    logic [DW-1:0] od;
    logic [1:0]    st;
    logic [3:0]    nib;
    s = 0;
    for (int i = 0; i < DW; i++) if (d[i]) s ^= dpos(i);
    for (int i = 0; i < PW - 1; i++) if (c[i]) s ^= (1 << i);
    p = ^{d, c};
    for (int j = 0; j < NL; j++) begin
      nib = k[4*j +: 4];
      if (nib == 4'h0) s &= ~(1 << j);
      else if (nib == 4'hF) s |= (1 << j);
    end
    od = d;
    if (s == 0 && !p) st = 2'b00;
    else if (p && s == 0) st = 2'b01;
    else if (p && s <= NPOS) begin
      st = 2'b01;
      for (int i = 0; i < DW; i++) if (dpos(i) == s) od[i] = ~od[i];
    end else st = 2'b10;
    return {st, od};
  endfunction

  // One clock: advance the model with the inputs present at the edge, then settle.
  task automatic step();
    bit en;
    bit xfer;
    @(posedge clk);
    if (rst) begin
      m_v1 = 0; m_v2 = 0; m_d2 = '0; m_s2 = '0; m_corr = 0; m_unc = 0; m_key = '0;
    end else begin
      en   = !m_v2 || out_ready;
      xfer = m_v2 && out_ready;
      if (cnt_clr) begin
        m_corr = 0; m_unc = 0;
      end else if (xfer) begin
        if (m_s2 == 2'b01 && m_corr < CMAX) m_corr++;
        if (m_s2 == 2'b10 && m_unc < CMAX) m_unc++;
      end
      if (en) begin
        if (m_v1) {m_s2, m_d2} = ref_decode(m_d1, m_c1, m_k1);
        m_v2 = m_v1;
        if (in_valid) begin
          m_d1 = in_data; m_c1 = in_chk; m_k1 = m_key;
        end
        m_v1 = in_valid;
      end
      if (key_shift) m_key = {m_key[KW-2:0], key_bit};
    end
    #1;
  endtask

  task automatic load_key(input logic [KW-1:0] k);
    for (int i = KW - 1; i >= 0; i--) begin
      key_shift = 1'b1;
      key_bit   = k[i];
      step();
    end
    key_shift = 1'b0;
    key_bit   = 1'b0;
  endtask

  function automatic logic [43:0] model_vec();
    return {(!m_v2 || out_ready), m_v2, (m_v2 ? m_d2 : {DW{1'b0}}), (m_v2 ? m_s2 : 2'b00),
            m_corr[CW-1:0], m_unc[CW-1:0]};
  endfunction

  function automatic logic [43:0] dut_vec();
    return {in_ready, out_valid, (out_valid ? out_data : {DW{1'b0}}),
            (out_valid ? out_stat : 2'b00), corr_cnt, uncorr_cnt};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; key_shift = 1'b0; cnt_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_chk++; if (out_stat !== 2'b00) begin n_fail++; $display("FAIL reset_out_stat: got %b want 00", out_stat); end
    n_chk++; if ({corr_cnt, uncorr_cnt} !== '0) begin n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", corr_cnt, uncorr_cnt); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_zero_key();
    logic [DW-1:0] d;
    d = 32'hDEADBEEF;
    out_ready = 1'b1;
    in_data = d ^ (32'h1 << 10); in_chk = encode(d); in_valid = 1'b1;
    step(); in_valid = 1'b0; step();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zkey_valid: got %b want 1", out_valid); end
    n_chk++; if (out_stat !== 2'b01) begin n_fail++; $display("FAIL zkey_stat: got %b want 01", out_stat); end
    n_chk++; if (out_data !== (d ^ (32'h1 << 10))) begin n_fail++; $display("FAIL zkey_data: got %h want %h", out_data, d ^ (32'h1 << 10)); end
    step();
    load_key(16'h6666);
    in_valid = 1'b1; step(); in_valid = 1'b0; step();
    n_chk++; if ({out_valid, out_stat, out_data} !== {1'b1, 2'b01, d}) begin n_fail++; $display("FAIL rekey_beat: got %b/%b/%h want 1/01/%h", out_valid, out_stat, out_data, d); end
    step();
  endtask

  task automatic test_clean();
    in_data = 32'hDEADBEEF; in_chk = encode(32'hDEADBEEF); in_valid = 1'b1; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clean_latency1: got valid %b want 0", out_valid); end
    step();
    n_chk++; if ({out_valid, out_stat, out_data} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin n_fail++; $display("FAIL clean_beat: got %b/%b/%h want 1/00/deadbeef", out_valid, out_stat, out_data); end
    n_chk++; if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL clean_model: dut %h model %h", dut_vec(), model_vec()); end
    step();
  endtask

  task automatic test_single_double();
    logic [DW-1:0] d;
    d = 32'hDEADBEEF;
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    in_data = d ^ 32'h20; in_chk = encode(d); in_valid = 1'b1;
    step(); in_valid = 1'b0; step();
    n_chk++; if ({out_valid, out_stat, out_data} !== {1'b1, 2'b01, d}) begin n_fail++; $display("FAIL single_beat: got %b/%b/%h want 1/01/%h", out_valid, out_stat, out_data, d); end
    step();
    n_chk++; if (corr_cnt !== 4'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", corr_cnt); end
    in_data = d ^ 32'h220; in_valid = 1'b1;
    step(); in_valid = 1'b0; step();
    n_chk++; if ({out_valid, out_stat, out_data} !== {1'b1, 2'b10, d ^ 32'h220}) begin n_fail++; $display("FAIL double_beat: got %b/%b/%h want 1/10/%h", out_valid, out_stat, out_data, d ^ 32'h220); end
    step();
    n_chk++; if ({corr_cnt, uncorr_cnt} !== {4'd1, 4'd1}) begin n_fail++; $display("FAIL double_cnt: got %0d/%0d want 1/1", corr_cnt, uncorr_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0]   dq[$];
    logic [PW-1:0]   cq[$];
    logic [DW+1:0]   eq[$];
    logic [DW-1:0]   d;
    logic [PW-1:0]   c;
    logic [DW+1:0]   held;
    int              sent, got, r;
    bit              acc, hold;
    sent = 0; got = 0;
    for (int i = 0; i < 8; i++) begin
      d = $urandom; c = encode(d); r = $urandom_range(0, 39);
      if (r < 32) d[r] = ~d[r];
      else if (r < 39) c[r-32] = ~c[r-32];
      dq.push_back(d); cq.push_back(c); eq.push_back(ref_decode(d, c, 16'h6666));
    end
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid  = (sent < 8);
      if (sent < 8) begin in_data = dq[sent]; in_chk = cq[sent]; end
      if (out_valid && out_ready) begin
        n_chk++; if ({out_stat, out_data} !== eq[got]) begin n_fail++; $display("FAIL b2b_beat%0d: got %h want %h", got, {out_stat, out_data}, eq[got]); end
        got++;
      end
      hold = out_valid && !out_ready;
      held = {out_stat, out_data};
      acc  = in_valid && (!m_v2 || out_ready);
      step();
      if (acc) sent++;
      n_chk++; if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL b2b_cyc%0d: dut %h model %h", cyc, dut_vec(), model_vec()); end
      if (hold) begin
        n_chk++; if ({out_stat, out_data} !== held) begin n_fail++; $display("FAIL b2b_hold%0d: got %h want %h", cyc, {out_stat, out_data}, held); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_ready%0d: got %b want 0", cyc, in_ready); end
      end
    end
    n_chk++; if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", got); end
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
  endtask

  task automatic test_saturation();
    logic [DW-1:0] d;
    int            sent, got;
    bit            acc;
    sent = 0; got = 0;
    out_ready = 1'b1;
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    for (int cyc = 0; cyc < 80 && got < 20; cyc++) begin
      in_valid = (sent < 20);
      d = $urandom; in_chk = encode(d); d[sent % DW] = ~d[sent % DW]; in_data = d;
      if (out_valid) got++;
      acc = in_valid && (!m_v2 || out_ready);
      step();
      if (acc) sent++;
      n_chk++; if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL sat_cyc%0d: dut %h model %h", cyc, dut_vec(), model_vec()); end
    end
    in_valid = 1'b0;
    n_chk++; if (corr_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_value: got %0d want 15", corr_cnt); end
    d = 32'h0F0F1234; in_chk = encode(d); in_data = d ^ 32'h8000_0000; in_valid = 1'b1;
    step(); in_valid = 1'b0; step();
    n_chk++; if ({out_valid, out_stat} !== 3'b101) begin n_fail++; $display("FAIL clr_pre: got %b/%b want 1/01", out_valid, out_stat); end
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    n_chk++; if (corr_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_wins: got %0d want 0", corr_cnt); end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic [PW-1:0] c;
    int            nerr, r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      d = $urandom; c = encode(d); nerr = $urandom_range(0, 3);
      for (int e = 0; e < nerr; e++) begin
        r = $urandom_range(0, 38);
        if (r < 32) d[r] = ~d[r]; else c[r-32] = ~c[r-32];
      end
      in_data = d; in_chk = c;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 19) == 0);
      step();
      n_chk++; if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL rand_cyc%0d: dut %h model %h", cyc, dut_vec(), model_vec()); end
    end
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] d;
    d = 32'hA5A5_0F0F;
    out_ready = 1'b1;
    in_data = d ^ 32'h3; in_chk = encode(d); in_valid = 1'b1;
    step(); in_valid = 1'b0; step(); step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = d;
    step(); step(); step();
    n_chk++; if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_full: got valid/ready %b%b want 10", out_valid, in_ready); end
    n_chk++; if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL mid_model: dut %h model %h", dut_vec(), model_vec()); end
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    n_chk++; if ({out_valid, in_ready, corr_cnt, uncorr_cnt} !== {2'b01, 8'h00}) begin n_fail++; $display("FAIL mid_reset: got %b%b %0d/%0d want 01 0/0", out_valid, in_ready, corr_cnt, uncorr_cnt); end
    out_ready = 1'b1; step(); step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discard: got valid %b want 0", out_valid); end
    in_data = d ^ (32'h1 << 10); in_chk = encode(d); in_valid = 1'b1;
    step(); in_valid = 1'b0; step();
    n_chk++; if ({out_valid, out_stat, out_data} !== {1'b1, 2'b01, d ^ (32'h1 << 10)}) begin n_fail++; $display("FAIL mid_zero_key: got %b/%b/%h want 1/01/%h", out_valid, out_stat, out_data, d ^ (32'h1 << 10)); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_key();
    test_clean();
    test_single_double();
    test_back_to_back();
    test_saturation();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
